// File: rtl/dmem_pkg.sv
// Shared types and constants for the CPU data-memory responder:
// FSM encoding, lane masks, reset levels and the access-error rule.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   localparam logic [3:0] SEL_WORD = 4'hF;
   localparam logic [3:0] SEL_NONE = 4'h0;

   // Reset is active-low: ENABLE is the level that holds the block in reset.
   localparam logic ENABLE  = 1'b0;
   localparam logic DISABLE = 1'b1;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
   } req_t;

   // Misaligned (low two bits set) or beyond the 2^aw-word array.
   function automatic logic access_error(input logic [31:0] addr, input int unsigned aw);
      return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered,
// holding read port that can be forced to zero on a faulted access.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic                    re_i,
   input  logic                    clr_i,
   output logic [DATA_WIDTH-1:0]   rdata_o
);

   localparam int NUM_LANES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // NOTE: the storage array has no reset; clearing 2^N words is neither
   // needed nor mappable onto RAM macros. Only the output register resets.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_LANES; b++) begin
         if (we_i && be_i[b]) begin
            mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == ENABLE) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= clr_i ? '0 : mem[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// CPU data-bus responder: captures a request, waits WAIT_CYCLES, then commits
// the store or samples the load and pulses ack_o for one cycle.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_i,
   input  logic                    we_i,
   input  logic [31:0]             addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] sel_i,
   output logic                    ack_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    err_o,
   output logic                    busy_o
);

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("dmem_responder: WAIT_CYCLES=%0d outside 0..15", WAIT_CYCLES);
   end
   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("dmem_responder: DATA_WIDTH must be 32");
   end

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   req_t       req_q, req_d;
   logic       err_q, err_d;

   req_t       live;
   req_t       cur;
   logic       access_en;
   logic       cur_err;

   assign live = '{we: we_i, addr: addr_i, wdata: wdata_i, sel: sel_i};

   // With zero wait states the RAM is accessed on the capture edge itself,
   // so the live request is used while still in IDLE.
   assign cur       = (state_q == ST_IDLE) ? live : req_q;
   assign cur_err   = access_error(cur.addr, ADDR_WIDTH);
   assign access_en = (state_d == ST_ACK) && (state_q != ST_ACK);

   // NOTE: every always_comb output gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               req_d = live;
               if (WAIT_LD == 4'd0) begin
                  state_d = ST_ACK;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LD;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      if (access_en) begin
         err_d = cur_err;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == ENABLE) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         req_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         err_q   <= err_d;
      end
   end

   dmem_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .addr_i  (cur.addr[ADDR_WIDTH+1:2]),
      .we_i    (access_en && cur.we && !cur_err),
      .be_i    (cur.sel),
      .wdata_i (cur.wdata),
      .re_i    (access_en && (!cur.we || cur_err)),
      .clr_i   (cur_err),
      .rdata_o (rdata_o)
   );

   assign ack_o  = (state_q == ST_ACK);
   assign err_o  = ack_o && err_q;
   assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_WIDTH=10, WAIT_CYCLES=2).
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [3:0]  sel_i;
   logic        ack_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        busy_o;

   int n_checks = 0;
   int n_errors = 0;

   dmem_responder #(
      .ADDR_WIDTH  (10),
      .DATA_WIDTH  (32),
      .WAIT_CYCLES (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req_i   (req_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .sel_i   (sel_i),
      .ack_o   (ack_o),
      .rdata_o (rdata_o),
      .err_o   (err_o),
      .busy_o  (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issues one request at a falling edge and waits (bounded) for ack_o.
   // lat counts falling-edge samples after the capture edge; -1 on timeout.
   task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] sel, input bit drop,
                       output logic [31:0] rdata, output logic err, output int lat);
      @(negedge clk);
      req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; sel_i = sel;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (drop) req_i = 1'b0;
         if (ack_o) begin
            lat = i;
            break;
         end
      end
      rdata = rdata_o;
      err   = err_o;
      req_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          acks;

      req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; sel_i = '0;
      rst = 1'b0;
      #30;
      rst = 1'b1;
      @(negedge clk);
      check("rst_ack",   32'(ack_o),  32'd0);
      check("rst_busy",  32'(busy_o), 32'd0);
      check("rst_rdata", rdata_o,     32'd0);
      check("rst_err",   32'(err_o),  32'd0);

      acks = 0;
      repeat (20) begin
         @(negedge clk);
         if (ack_o) acks++;
      end
      check("idle_no_ack", 32'(acks), 32'd0);

      // Store/load at WAIT_CYCLES=2: ack in the 3rd cycle after capture.
      xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, lat);
      check("st10_lat", 32'(lat), 32'd3);
      check("st10_err", 32'(er),  32'd0);
      @(negedge clk);
      check("ack_one_cycle", 32'(ack_o), 32'd0);
      xfer(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, er, lat);
      check("ld10_lat",   32'(lat), 32'd3);
      check("ld10_rdata", rd,       32'hDEADBEEF);
      check("ld10_err",   32'(er),  32'd0);
      repeat (3) @(negedge clk);
      check("rdata_hold", rdata_o, 32'hDEADBEEF);

      // Byte lanes 0 and 2 only.
      xfer(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, rd, er, lat);
      xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, rd, er, lat);
      xfer(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er, lat);
      check("lanes_rdata", rd, 32'h11BB33DD);

      // Empty lane mask: acked, no error, no write.
      xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, rd, er, lat);
      check("sel0_lat", 32'(lat), 32'd3);
      check("sel0_err", 32'(er),  32'd0);
      xfer(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, rd, er, lat);
      check("sel0_nowrite", rd, 32'h11BB33DD);

      // Errors: misaligned load, out-of-range store aliasing word 0.
      xfer(1'b1, 32'h0, 32'h01234567, 4'hF, 1'b0, rd, er, lat);
      xfer(1'b0, 32'h12, 32'h0, 4'hF, 1'b0, rd, er, lat);
      check("mis_err",   32'(er), 32'd1);
      check("mis_rdata", rd,      32'd0);
      xfer(1'b1, 32'h00001000, 32'hFFFFFFFF, 4'hF, 1'b0, rd, er, lat);
      check("oor_err", 32'(er),  32'd1);
      check("oor_lat", 32'(lat), 32'd3);
      xfer(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, rd, er, lat);
      check("oor_word0", rd,      32'h01234567);
      check("ok_err",    32'(er), 32'd0);

      // Highest legal word, with req_i withdrawn during WAIT.
      xfer(1'b1, 32'hFFC, 32'h600DCAFE, 4'hF, 1'b1, rd, er, lat);
      check("drop_lat", 32'(lat), 32'd3);
      check("top_err",  32'(er),  32'd0);
      xfer(1'b0, 32'hFFC, 32'h0, 4'hF, 1'b0, rd, er, lat);
      check("top_rdata", rd, 32'h600DCAFE);

      // Back-to-back with req_i held across ACK: pulses 4 cycles apart.
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; wdata_i = 32'hA5A5A5A5; sel_i = 4'hF;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ack_o) begin
            lat = i;
            break;
         end
      end
      check("b2b_first_lat", 32'(lat), 32'd3);
      addr_i = 32'h4; wdata_i = 32'h5A5A5A5A;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ack_o) begin
            lat = i;
            break;
         end
      end
      check("b2b_spacing", 32'(lat), 32'd4);
      req_i = 1'b0;
      xfer(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, rd, er, lat);
      check("b2b_word0", rd, 32'hA5A5A5A5);
      xfer(1'b0, 32'h4, 32'h0, 4'hF, 1'b0, rd, er, lat);
      check("b2b_word1", rd, 32'h5A5A5A5A);

      // Reset during WAIT discards the uncommitted store.
      xfer(1'b1, 32'h8, 32'h13579BDF, 4'hF, 1'b0, rd, er, lat);
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b1; addr_i = 32'h8; wdata_i = 32'hCAFEF00D; sel_i = 4'hF;
      @(negedge clk);
      check("midrst_busy_pre", 32'(busy_o), 32'd1);
      req_i = 1'b0;
      rst = 1'b0;
      #1;
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_ack",  32'(ack_o),  32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      acks = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack_o) acks++;
      end
      check("midrst_no_ack", 32'(acks), 32'd0);
      xfer(1'b0, 32'h8, 32'h0, 4'hF, 1'b0, rd, er, lat);
      check("midrst_word", rd, 32'h13579BDF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
